// File: rtl/hwpe_stream_tcdm_fifo_store_pkg.sv
// Shared types for the store-side TCDM decoupler: the buffered write payload.
package hwpe_stream_tcdm_fifo_store_pkg;

  localparam int HWPE_TCDM_STORE_WIDTH = 68;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] add;
  } tcdm_store_t;

endpackage

// File: rtl/hwpe_stream_tcdm_fifo_store_if.sv
// TCDM request/response bundle; master issues requests, slave grants and answers.
interface hwpe_stream_tcdm_fifo_store_if;
  // A request transfers on a cycle with req & gnt; req and payload hold until then.
  // r_valid is a one-cycle response pulse, with no back-pressure.
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_fifo_store_fifo.sv
// Registered-pointer FIFO holding buffered writes; LATCH_FIFO selects latch storage.
module hwpe_stream_tcdm_fifo_store_fifo #(
  parameter int DATA_WIDTH = 68,
  parameter int FIFO_DEPTH = 8,
  parameter int LATCH_FIFO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]           wptr_q, rptr_q;
  logic                  full, push, pop;
  logic [DATA_WIDTH-1:0] rd_arr [FIFO_DEPTH];

  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;
  assign pop_data   = rd_arr[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_entry
    logic [DATA_WIDTH-1:0] entry;
    logic                  we;
    assign we        = push && (wptr_q[AW-1:0] == AW'(i));
    assign rd_arr[i] = entry;
    if (LATCH_FIFO != 0) begin : g_latch
      // Transparent in the low clock phase so the entry settles before the pointer moves.
      always_latch begin
        if (!clk && we) entry <= push_data;
      end
    end else begin : g_flop
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  entry <= '0;
        else if (we) entry <= push_data;
      end
    end
  end
endmodule

// File: rtl/hwpe_stream_tcdm_fifo_store.sv
// Store-side TCDM decoupler: acks streamer writes locally, replays them with bounded outstanding.
// Optional stall counter enabled by defining HWPE_TCDM_FIFO_STORE_PERF_EN.
module hwpe_stream_tcdm_fifo_store
  import hwpe_stream_tcdm_fifo_store_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int LATCH_FIFO      = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  output logic                                idle_o,
  output logic [31:0]                         stall_cnt_o,
  hwpe_stream_tcdm_fifo_store_if.slave        tcdm_slave,
  hwpe_stream_tcdm_fifo_store_if.master       tcdm_master
);
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  tcdm_store_t          push_data, pop_data;
  logic                 push_ready, pop_valid, pop_ready, fifo_empty;
  logic                 rvalid_q;
  logic [CNT_WIDTH-1:0] outst_q;
  logic                 inc, dec;
  logic                 unused_sig;

  assign push_data = '{be: tcdm_slave.be, data: tcdm_slave.data, add: tcdm_slave.add};

  hwpe_stream_tcdm_fifo_store_fifo #(
    .DATA_WIDTH (HWPE_TCDM_STORE_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LATCH_FIFO (LATCH_FIFO)
  ) i_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clear      (clear_i),
    .push_valid (tcdm_slave.req),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .empty      (fifo_empty)
  );

  // Grant is held low while in reset so no write is acked into a FIFO that cannot store it.
  assign tcdm_slave.gnt    = push_ready & rst_ni;
  assign tcdm_slave.r_valid = rvalid_q;
  assign tcdm_slave.r_data  = '0;

  assign tcdm_master.req  = pop_valid & (outst_q < CNT_WIDTH'(MAX_OUTSTANDING));
  assign tcdm_master.wen  = 1'b0;
  assign tcdm_master.add  = pop_data.add;
  assign tcdm_master.data = pop_data.data;
  assign tcdm_master.be   = pop_data.be;
  assign pop_ready        = tcdm_master.req & tcdm_master.gnt;

  // Responses arriving with nothing outstanding (e.g. after a clear) are dropped.
  assign inc = tcdm_master.req & tcdm_master.gnt;
  assign dec = tcdm_master.r_valid & (outst_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (clear_i) begin
      outst_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= tcdm_slave.req & tcdm_slave.gnt;
      if (inc && !dec)      outst_q <= outst_q + CNT_WIDTH'(1);
      else if (dec && !inc) outst_q <= outst_q - CNT_WIDTH'(1);
    end
  end

  assign idle_o = fifo_empty & (outst_q == '0) & ~tcdm_slave.req & ~rvalid_q;

`ifdef HWPE_TCDM_FIFO_STORE_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                     stall_q <= '0;
    else if (clear_i)                                stall_q <= '0;
    else if (tcdm_master.req && !tcdm_master.gnt)    stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign unused_sig = ^tcdm_master.r_data ^ tcdm_slave.wen;

`ifndef SYNTHESIS
  // Reads are not supported; a read request is still buffered as a write.
  wen_is_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tcdm_slave.req |-> !tcdm_slave.wen);
`endif
endmodule

// File: tb/tb_hwpe_stream_tcdm_fifo_store.sv
// Directed bench for the store decoupler with a payload scoreboard on the master side.
module tb_hwpe_stream_tcdm_fifo_store;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        idle_o;
  logic [31:0] stall_cnt_o;

  hwpe_stream_tcdm_fifo_store_if slv ();
  hwpe_stream_tcdm_fifo_store_if mst ();

  hwpe_stream_tcdm_fifo_store dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .idle_o      (idle_o),
    .stall_cnt_o (stall_cnt_o),
    .tcdm_slave  (slv),
    .tcdm_master (mst)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [67:0] exp_q[$];
  int  mst_hs = 0;
  int  stall_model = 0;
  logic last_mst_hs = 1'b0;
  logic prev_slv_hs = 1'b0;
  logic prev_chk = 1'b0;
  logic auto_rv = 1'b0;
  logic man_rv = 1'b0;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_stall();
`ifdef HWPE_TCDM_FIFO_STORE_PERF_EN
    return 32'(stall_model);
`else
    return 32'd0;
`endif
  endfunction

  // Interconnect model: r_valid one cycle after each grant, or manual pulses.
  always @(posedge clk) begin
    #2;
    mst.r_valid = auto_rv ? last_mst_hs : man_rv;
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      prev_slv_hs = 1'b0;
      prev_chk    = 1'b1;
      last_mst_hs = 1'b0;
      stall_model = 0;
    end else begin
      if (prev_chk) chk("slave_r_valid", 68'(slv.r_valid), 68'(prev_slv_hs));
      prev_chk    = !clear_i;
      prev_slv_hs = slv.req && slv.gnt;
      last_mst_hs = mst.req && mst.gnt;
      if (clear_i)                    stall_model = 0;
      else if (mst.req && !mst.gnt)   stall_model++;
      if (mst.req) chk("master_wen", 68'(mst.wen), 68'(0));
      if (mst.req && mst.gnt) begin
        mst_hs++;
        if (exp_q.size() == 0) chk("master_unexpected_pop", 68'(1), 68'(0));
        else chk("master_payload", {mst.be, mst.data, mst.add}, exp_q.pop_front());
      end
      if (slv.req && slv.gnt) exp_q.push_back({slv.be, slv.data, slv.add});
      if (clear_i) exp_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_n(input int n, input logic [31:0] base, input string tag);
    int k = 0;
    int t = 0;
    logic [31:0] d = $urandom;
    logic [3:0]  b = 4'($urandom_range(1, 15));
    while (k < n && t < 200) begin
      slv.req  = 1'b1;
      slv.add  = base + 32'(4 * k);
      slv.data = d;
      slv.be   = b;
      @(negedge clk);
      if (slv.gnt) begin
        k++;
        d = $urandom;
        b = 4'($urandom_range(1, 15));
      end
      @(posedge clk);
      #1;
      t++;
    end
    slv.req = 1'b0;
    chk(tag, 68'(k), 68'(n));
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    while (!idle_o && n < maxc) begin
      cyc(1);
      n++;
    end
    chk(tag, 68'(idle_o), 68'(1));
  endtask

  task automatic drain(input string tag);
    man_rv = 1'b1;
    mst.gnt = 1'b1;
    cyc(12);
    man_rv = 1'b0;
    wait_idle(10, tag);
    chk({tag, "_sb_empty"}, 68'(exp_q.size()), 68'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int accepted;
    logic have_head;
    logic [67:0] head;
    logic [31:0] d2 [10];

    slv.req = 1'b0; slv.wen = 1'b0; slv.add = '0; slv.data = '0; slv.be = '0;
    mst.gnt = 1'b0; mst.r_data = '0;

    cyc(3);
    chk("rst_slave_gnt",     68'(slv.gnt), 68'(0));
    chk("rst_slave_r_valid", 68'(slv.r_valid), 68'(0));
    chk("rst_slave_r_data",  68'(slv.r_data), 68'(0));
    chk("rst_master_req",    68'(mst.req), 68'(0));
    chk("rst_idle",          68'(idle_o), 68'(1));
    chk("rst_stall",         68'(stall_cnt_o), 68'(0));
    rst_ni = 1'b1;
    cyc(1);
    chk("post_rst_slave_gnt", 68'(slv.gnt), 68'(1));

    // 1: burst of 8 with free-flowing interconnect
    mst.gnt = 1'b1; auto_rv = 1'b1; base = mst_hs;
    for (int i = 0; i < 8; i++) begin
      slv.req  = 1'b1;
      slv.add  = 32'h100 + 32'(4 * i);
      slv.data = $urandom;
      slv.be   = 4'($urandom_range(1, 15));
      @(negedge clk);
      chk("t1_slave_gnt", 68'(slv.gnt), 68'(1));
      if (i == 0) chk("t1_latency_same_cycle", 68'(mst.req), 68'(0));
      if (i == 1) chk("t1_latency_next_cycle", 68'(mst.req), 68'(1));
      @(posedge clk);
      #1;
    end
    slv.req = 1'b0;
    wait_idle(10, "t1_idle");
    chk("t1_grants", 68'(mst_hs - base), 68'(8));
    chk("t1_sb_empty", 68'(exp_q.size()), 68'(0));

    // 2: interconnect stalled for 20 cycles, 10 writes offered
    for (int i = 0; i < 10; i++) d2[i] = $urandom;
    mst.gnt = 1'b0; accepted = 0; have_head = 1'b0; head = '0;
    for (int c = 0; c < 20; c++) begin
      slv.req  = 1'b1;
      slv.add  = 32'h200 + 32'(4 * accepted);
      slv.data = d2[accepted];
      slv.be   = 4'hF;
      @(negedge clk);
      if (slv.gnt) accepted++;
      if (mst.req) begin
        if (!have_head) begin
          have_head = 1'b1;
          head = {mst.be, mst.data, mst.add};
        end else chk("t2_head_stable", {mst.be, mst.data, mst.add}, head);
      end
      @(posedge clk);
      #1;
    end
    chk("t2_accepts_when_full", 68'(accepted), 68'(8));
    chk("t2_slave_gnt_low", 68'(slv.gnt), 68'(0));
    chk("t2_stall_cnt", 68'(stall_cnt_o), 68'(exp_stall()));
    mst.gnt = 1'b1;
    for (int n = 0; n < 20 && accepted < 10; n++) begin
      slv.req  = 1'b1;
      slv.add  = 32'h200 + 32'(4 * accepted);
      slv.data = d2[accepted];
      @(negedge clk);
      if (slv.gnt) accepted++;
      @(posedge clk);
      #1;
    end
    slv.req = 1'b0;
    chk("t2_all_accepted", 68'(accepted), 68'(10));
    wait_idle(10, "t2_idle");
    chk("t2_sb_empty", 68'(exp_q.size()), 68'(0));

    // 3: responses withheld, outstanding limit
    auto_rv = 1'b0; man_rv = 1'b0; mst.gnt = 1'b1; base = mst_hs;
    push_n(6, 32'h300, "t3_push");
    cyc(4);
    chk("t3_grants_at_limit", 68'(mst_hs - base), 68'(4));
    chk("t3_req_blocked", 68'(mst.req), 68'(0));
    man_rv = 1'b1;
    cyc(1);
    man_rv = 1'b0;
    cyc(3);
    chk("t3_one_more_grant", 68'(mst_hs - base), 68'(5));
    chk("t3_req_blocked_again", 68'(mst.req), 68'(0));
    drain("t3_drain");
    chk("t3_total_grants", 68'(mst_hs - base), 68'(6));

    // 4: grant and response in the same cycle at outst=2
    mst.gnt = 1'b0; base = mst_hs;
    push_n(6, 32'h400, "t4_push");
    mst.gnt = 1'b1;
    cyc(2);
    man_rv = 1'b1;
    cyc(1);
    man_rv = 1'b0;
    cyc(4);
    chk("t4_grants", 68'(mst_hs - base), 68'(5));
    chk("t4_req_blocked", 68'(mst.req), 68'(0));
    drain("t4_drain");

    // 5: clear with 5 queued and 3 outstanding
    mst.gnt = 1'b0;
    push_n(8, 32'h500, "t5_push");
    chk("t5_full_gnt_low", 68'(slv.gnt), 68'(0));
    mst.gnt = 1'b1;
    cyc(3);
    mst.gnt = 1'b0;
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
    chk("t5_req_after_clear", 68'(mst.req), 68'(0));
    chk("t5_idle_after_clear", 68'(idle_o), 68'(1));
    chk("t5_stall_after_clear", 68'(stall_cnt_o), 68'(exp_stall()));
    man_rv = 1'b1;
    cyc(1);
    man_rv = 1'b0;
    cyc(1);
    chk("t5_idle_after_late_rvalid", 68'(idle_o), 68'(1));
    base = mst_hs; mst.gnt = 1'b1;
    push_n(5, 32'h600, "t5_push2");
    cyc(4);
    chk("t5_counter_zeroed", 68'(mst_hs - base), 68'(4));
    drain("t5_drain");

    // 6: asynchronous reset in the middle of a burst
    auto_rv = 1'b1; mst.gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slv.req  = 1'b1;
      slv.add  = 32'h700 + 32'(4 * i);
      slv.data = $urandom;
      slv.be   = 4'hF;
      cyc(1);
    end
    #2;
    rst_ni  = 1'b0;
    slv.req = 1'b0;
    #1;
    chk("t6_slave_gnt",     68'(slv.gnt), 68'(0));
    chk("t6_slave_r_valid", 68'(slv.r_valid), 68'(0));
    chk("t6_master_req",    68'(mst.req), 68'(0));
    chk("t6_idle",          68'(idle_o), 68'(1));
    chk("t6_stall",         68'(stall_cnt_o), 68'(0));
    cyc(2);
    rst_ni = 1'b1;
    cyc(1);
    push_n(2, 32'h800, "t6_push_after_reset");
    wait_idle(10, "t6_idle_after_reset");
    chk("t6_sb_empty", 68'(exp_q.size()), 68'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
